// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, fetch state encoding and IF/ID control codes.
// Also provides a saturating increment used by the optional perf counters.
package cpu_pkg;

    localparam int          ADDR_W    = 8;
    localparam int          PC_STEP   = 4;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_ctrl_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read bus between the fetch stage and the memory bank.
// The fetch stage is the master; the address is a byte address.
interface fetch_stage_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
);
    logic              imem_read;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_read,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_read,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with hold, flush (bubble) and load controls.
// A flush writes NOP_WORD, clears valid and zeroes the stored pc+4.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ifid_ctrl_e        ctrl,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc4,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_WORD;
            pc4   <= '0;
            valid <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    instr <= load_instr;
                    pc4   <= load_pc4;
                    valid <= 1'b1;
                end
                IFID_FLUSH: begin
                    instr <= NOP_WORD;
                    pc4   <= '0;
                    valid <= 1'b0;
                end
                default: begin
                    instr <= instr;
                    pc4   <= pc4;
                    valid <= valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and BOOT/RUN/HALT fetch FSM, drives the memory bus and IF/ID.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_stall/perf_flush counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = cpu_pkg::HALT_WORD,
    parameter logic [31:0]       NOP_WORD  = cpu_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    fetch_stage_if.master     imem,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall,
    output logic [15:0]       perf_flush
`endif
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    ifid_ctrl_e        ifid_ctrl;

    assign pc_plus4       = pc + ADDR_W'(PC_STEP);
    assign imem.imem_addr = pc;
    assign imem.imem_read = (state == RUN);
    assign halted         = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // An EX redirect beats the younger ID jump, and both beat a stall; in HALT only EX can leave.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_ctrl  = IFID_HOLD;
        case (state)
            BOOT: begin
                state_next = RUN;
                ifid_ctrl  = IFID_FLUSH;
            end
            RUN: begin
                if (ex_branch_taken) begin
                    pc_next   = ex_branch_target;
                    ifid_ctrl = IFID_FLUSH;
                end else if (id_jump) begin
                    pc_next   = id_jump_target;
                    ifid_ctrl = IFID_FLUSH;
                end else if (stall) begin
                    ifid_ctrl = IFID_HOLD;
                end else if (imem.imem_rdata == HALT_WORD) begin
                    state_next = HALT;
                    ifid_ctrl  = IFID_FLUSH;
                end else begin
                    pc_next   = pc_plus4;
                    ifid_ctrl = IFID_LOAD;
                end
            end
            HALT: begin
                ifid_ctrl = IFID_FLUSH;
                if (ex_branch_taken) begin
                    pc_next    = ex_branch_target;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
                ifid_ctrl  = IFID_FLUSH;
            end
        endcase
    end

    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl       (ifid_ctrl),
        .load_instr (imem.imem_rdata),
        .load_pc4   (pc_plus4),
        .instr      (ifid_instr),
        .pc4        (ifid_pc4),
        .valid      (ifid_valid)
    );

`ifdef FETCH_PERF_EN
    logic ev_fetch;
    logic ev_stall;
    logic ev_flush;

    always_comb begin
        ev_fetch = (ifid_ctrl == IFID_LOAD);
        ev_stall = 1'b0;
        ev_flush = 1'b0;
        if (state == RUN) begin
            ev_stall = stall && !ex_branch_taken && !id_jump;
            ev_flush = ex_branch_taken || id_jump;
        end else if (state == HALT) begin
            ev_flush = ex_branch_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (ev_fetch) perf_fetched <= sat_inc16(perf_fetched);
            if (ev_stall) perf_stall   <= sat_inc16(perf_stall);
            if (ev_flush) perf_flush   <= sat_inc16(perf_flush);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven and randomized self-checking bench for fetch_stage.
// A word-array memory model feeds imem_rdata; a rule-level model predicts IF/ID each edge.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [7:0]  ex_branch_target = '0;
    logic        id_jump = 1'b0;
    logic [7:0]  id_jump_target = '0;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
    logic [15:0] perf_flush;
`endif

    logic [31:0] mem [0:63];
    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_stage_if #(.ADDR_W(8)) bus ();

    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .imem             (bus),
        .ifid_instr       (ifid_instr),
        .ifid_pc4         (ifid_pc4),
        .ifid_valid       (ifid_valid),
        .halted           (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_stall       (perf_stall),
        .perf_flush       (perf_flush)
`endif
    );

    typedef struct {
        logic        st;
        logic        br;
        logic [7:0]  bt;
        logic        jp;
        logic [7:0]  jt;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [7:0]  e_pc4;
        logic [7:0]  e_pc;
        logic        e_halted;
        logic        e_read;
    } vec_t;

    vec_t tbl [17];

    // Reference model state: program-level view of fetch, independent of the RTL encoding.
    logic [7:0]  m_pc;
    bit          m_booting;
    bit          m_stopped;
    logic [31:0] m_instr;
    logic [7:0]  m_pc4;
    logic        m_valid;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic br, input logic [7:0] bt,
                                  input logic jp, input logic [7:0] jt);
        stall            = st;
        ex_branch_taken  = br;
        ex_branch_target = bt;
        id_jump          = jp;
        id_jump_target   = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        ex_branch_target = '0; id_jump_target = '0;
        @(posedge clk);
        #1;
        check_output("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check_output("rst_instr", ifid_instr, NOP_WORD);
        check_output("rst_read", {31'b0, bus.imem_read}, 32'd0);
        rst_n = 1'b1;
        m_pc = 8'h00; m_booting = 1'b1; m_stopped = 1'b0;
        m_instr = NOP_WORD; m_pc4 = 8'h00; m_valid = 1'b0;
    endtask

    function automatic void model_bubble();
        m_instr = NOP_WORD;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge(input logic st, input logic br, input logic [7:0] bt,
                                       input logic jp, input logic [7:0] jt);
        logic [31:0] word;
        word = mem[m_pc / 4];
        if (m_booting) begin
            m_booting = 1'b0;
            model_bubble();
        end else if (m_stopped) begin
            model_bubble();
            if (br) begin
                m_pc = bt;
                m_stopped = 1'b0;
            end
        end else if (br) begin
            m_pc = bt;
            model_bubble();
        end else if (jp) begin
            m_pc = jt;
            model_bubble();
        end else if (st) begin
            // everything holds
        end else if (word == 32'hFFFF_FFFF) begin
            m_stopped = 1'b1;
            model_bubble();
        end else begin
            m_instr = word;
            m_pc4   = 8'((int'(m_pc) + 4) % 256);
            m_valid = 1'b1;
            m_pc    = m_pc4;
        end
    endfunction

    function automatic vec_t mk(input logic st, input logic br, input logic [7:0] bt,
                                input logic jp, input logic [7:0] jt, input logic [31:0] ei,
                                input logic ev, input logic [7:0] ep4, input logic [7:0] epc,
                                input logic eh, input logic er);
        vec_t v;
        v = '{st, br, bt, jp, jt, ei, ev, ep4, epc, eh, er};
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0]  = 32'h200f0008;
        mem[1]  = 32'hac0f0000;
        mem[2]  = 32'h200f0017;
        mem[3]  = 32'hac0f0001;
        mem[10] = 32'h8c0f0004;
        mem[11] = 32'hFFFF_FFFF;
        mem[63] = 32'h1234_5678;

        tbl[0]  = mk(0,0,8'h00,0,8'h00, 32'h0,        0, 8'h00, 8'h00, 0, 1);
        tbl[1]  = mk(0,0,8'h00,0,8'h00, 32'h200f0008, 1, 8'h04, 8'h04, 0, 1);
        tbl[2]  = mk(0,0,8'h00,0,8'h00, 32'hac0f0000, 1, 8'h08, 8'h08, 0, 1);
        tbl[3]  = mk(1,0,8'h00,0,8'h00, 32'hac0f0000, 1, 8'h08, 8'h08, 0, 1);
        tbl[4]  = mk(1,0,8'h00,0,8'h00, 32'hac0f0000, 1, 8'h08, 8'h08, 0, 1);
        tbl[5]  = mk(1,0,8'h00,0,8'h00, 32'hac0f0000, 1, 8'h08, 8'h08, 0, 1);
        tbl[6]  = mk(0,0,8'h00,0,8'h00, 32'h200f0017, 1, 8'h0C, 8'h0C, 0, 1);
        tbl[7]  = mk(0,0,8'h00,0,8'h00, 32'hac0f0001, 1, 8'h10, 8'h10, 0, 1);
        tbl[8]  = mk(1,1,8'h28,1,8'h10, 32'h0,        0, 8'h00, 8'h28, 0, 1);
        tbl[9]  = mk(0,0,8'h00,0,8'h00, 32'h8c0f0004, 1, 8'h2C, 8'h2C, 0, 1);
        tbl[10] = mk(0,0,8'h00,0,8'h00, 32'h0,        0, 8'h00, 8'h2C, 1, 0);
        tbl[11] = mk(0,0,8'h00,1,8'h10, 32'h0,        0, 8'h00, 8'h2C, 1, 0);
        tbl[12] = mk(1,0,8'h00,0,8'h00, 32'h0,        0, 8'h00, 8'h2C, 1, 0);
        tbl[13] = mk(0,1,8'h00,0,8'h00, 32'h0,        0, 8'h00, 8'h00, 0, 1);
        tbl[14] = mk(0,0,8'h00,0,8'h00, 32'h200f0008, 1, 8'h04, 8'h04, 0, 1);
        tbl[15] = mk(0,0,8'h00,1,8'h03, 32'h0,        0, 8'h00, 8'h03, 0, 1);
        tbl[16] = mk(0,0,8'h00,0,8'h00, 32'h200f0008, 1, 8'h07, 8'h07, 0, 1);

        $display("[TB] directed vector table");
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt);
            check_output($sformatf("tbl%0d_instr", i), ifid_instr, tbl[i].e_instr);
            check_output($sformatf("tbl%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) check_output($sformatf("tbl%0d_pc4", i), {24'b0, ifid_pc4}, {24'b0, tbl[i].e_pc4});
            check_output($sformatf("tbl%0d_pc", i), {24'b0, bus.imem_addr}, {24'b0, tbl[i].e_pc});
            check_output($sformatf("tbl%0d_halted", i), {31'b0, halted}, {31'b0, tbl[i].e_halted});
            check_output($sformatf("tbl%0d_read", i), {31'b0, bus.imem_read}, {31'b0, tbl[i].e_read});
        end

        $display("[TB] PC wrap at 8'hFC");
        do_reset();
        apply_stimulus(0, 0, 8'h00, 0, 8'h00);
        apply_stimulus(0, 0, 8'h00, 1, 8'hFC);
        check_output("wrap_pc_fc", {24'b0, bus.imem_addr}, 32'h0000_00FC);
        apply_stimulus(0, 0, 8'h00, 0, 8'h00);
        check_output("wrap_instr", ifid_instr, 32'h1234_5678);
        check_output("wrap_pc4", {24'b0, ifid_pc4}, 32'h0);
        check_output("wrap_pc", {24'b0, bus.imem_addr}, 32'h0);
        apply_stimulus(0, 0, 8'h00, 0, 8'h00);
        check_output("pre_rst_valid", {31'b0, ifid_valid}, 32'd1);

        $display("[TB] asynchronous reset between edges");
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_valid", {31'b0, ifid_valid}, 32'd0);
        check_output("arst_instr", ifid_instr, NOP_WORD);
        check_output("arst_pc4", {24'b0, ifid_pc4}, 32'd0);
        check_output("arst_pc", {24'b0, bus.imem_addr}, 32'd0);
        check_output("arst_read", {31'b0, bus.imem_read}, 32'd0);
        check_output("arst_halted", {31'b0, halted}, 32'd0);
        #1 rst_n = 1'b1;
        apply_stimulus(0, 0, 8'h00, 0, 8'h00);
        check_output("arst_boot_valid", {31'b0, ifid_valid}, 32'd0);
        check_output("arst_boot_pc", {24'b0, bus.imem_addr}, 32'd0);
        apply_stimulus(0, 0, 8'h00, 0, 8'h00);
        check_output("arst_first_instr", ifid_instr, 32'h200f0008);
        check_output("arst_first_pc4", {24'b0, ifid_pc4}, 32'd4);

        $display("[TB] randomized run against reference model");
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic st, br, jp;
            logic [7:0] bt, jt;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            jp = ($urandom_range(0, 5) == 0);
            bt = 8'($urandom);
            jt = 8'($urandom);
            if ($urandom_range(0, 4) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 4) != 0) jt[1:0] = 2'b00;
            model_edge(st, br, bt, jp, jt);
            apply_stimulus(st, br, bt, jp, jt);
            check_output("rnd_instr", ifid_instr, m_instr);
            check_output("rnd_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            if (m_valid) check_output("rnd_pc4", {24'b0, ifid_pc4}, {24'b0, m_pc4});
            check_output("rnd_pc", {24'b0, bus.imem_addr}, {24'b0, m_pc});
            check_output("rnd_halted", {31'b0, halted}, {31'b0, m_stopped});
            check_output("rnd_read", {31'b0, bus.imem_read}, {31'b0, !m_stopped});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
